perf_counter_bank: RTL and testbench

Synthesizable performance-monitor bank that accumulates up to NUM_CH per-cycle event streams from the core (queue occupancy, free entries, mispredicts, dispatch counts, busy FUs) alongside a cycle counter. Snapshots are taken periodically or on demand into shadow registers, which are read without disturbing live counting. It sits beside `cpu` and is fed by wires from rename/dispatch, ROB, LSQ, branch queue and CDB, so a testbench or debug port can read figures such as occupancy averages and mispredict rate from hardware.

---
 rtl/perf_counter_bank.sv | 133 +++++++++++++
 tb/tb_perf_counter_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
//
// Performance-monitor bank: NUM_CH per-cycle event channels plus a cycle
// counter, with snapshot shadow registers that are read through a
// combinational mux while live counting continues undisturbed.
//
// Optional feature macro: PERF_CNT_SAT_EN
//   defined   -> counters saturate at 2^CNT_W-1 on overflow
//   undefined -> counters wrap modulo 2^CNT_W
//   In both builds the sticky overflow bit of the counter is set.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset (overrides everything)
//   en          counting enable; 0 freezes all live counters
//   clear       zero live counters, window counter and overflow flags
//   inc         per-channel increments, channel i at [i*INC_W +: INC_W]
//   mode        per channel: 0 = add inc, 1 = add 1 when inc != 0
//   window_len  periodic snapshot interval in counted cycles (0 = off)
//   snap_req    on-demand snapshot pulse
//   snap_valid  one-cycle pulse after the edge that updated the shadows
//   rd_sel      0..NUM_CH-1 channel, NUM_CH cycle count, above reads 0
//   rd_data     shadow value for rd_sel
//   overflow    sticky per-counter overflow flags, bit NUM_CH = cycles
module perf_counter_bank #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 48,
    parameter int INC_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          clear,
    input  logic [NUM_CH*INC_W-1:0]       inc,
    input  logic [NUM_CH-1:0]             mode,
    input  logic [31:0]                   window_len,
    input  logic                          snap_req,
    output logic                          snap_valid,
    input  logic [$clog2(NUM_CH+2)-1:0]   rd_sel,
    output logic [CNT_W-1:0]              rd_data,
    output logic [NUM_CH:0]               overflow
);

    localparam int SEL_W = $clog2(NUM_CH+2);

    // Counter index NUM_CH is the cycle counter; 0..NUM_CH-1 are channels.
    logic [CNT_W-1:0] cnt_p1    [NUM_CH+1];
    logic [CNT_W-1:0] shadow_p1 [NUM_CH+1];
    logic [NUM_CH:0]  ovf_p1;
    logic [31:0]      win_p1;
    logic             vld_p1;

    logic [CNT_W-1:0] addend    [NUM_CH+1];
    logic [CNT_W-1:0] nxt       [NUM_CH+1];
    logic [NUM_CH:0]  carry;
    logic             counted;
    logic [31:0]      win_inc;
    logic             periodic;
    logic             fire;

    // Returns {carry, result}; with saturation enabled the result pins at
    // all-ones whenever the add carries out.
    function automatic logic [CNT_W:0] add_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef PERF_CNT_SAT_EN
        if (s[CNT_W]) s[CNT_W-1:0] = '1;
`endif
        return s;
    endfunction

    // The "next" value includes this cycle's increment even when clear is
    // high, because a coincident snapshot must capture pre-clear + inc.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            addend[i] = '0;
            if (en) begin
                if (mode[i]) addend[i] = CNT_W'(|inc[i*INC_W +: INC_W]);
                else         addend[i] = CNT_W'(inc[i*INC_W +: INC_W]);
            end
        end
        addend[NUM_CH] = CNT_W'(en);
        for (int i = 0; i <= NUM_CH; i++) begin
            {carry[i], nxt[i]} = add_cnt(cnt_p1[i], addend[i]);
        end
    end

    assign counted  = en & ~clear;
    assign win_inc  = win_p1 + 32'd1;
    // Equality (not >=) so a window_len lowered below win waits for the wrap.
    assign periodic = counted && (window_len != 32'd0) && (win_inc == window_len);
    assign fire     = snap_req | periodic;

    // ---- stage p1: live counters, window, shadows, snapshot pulse ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NUM_CH; i++) begin
                cnt_p1[i]    <= '0;
                shadow_p1[i] <= '0;
            end
            ovf_p1 <= '0;
            win_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= fire;
            if (fire) begin
                for (int i = 0; i <= NUM_CH; i++) shadow_p1[i] <= nxt[i];
            end
            if (clear) begin
                for (int i = 0; i <= NUM_CH; i++) cnt_p1[i] <= '0;
                ovf_p1 <= '0;
                win_p1 <= '0;
            end else begin
                for (int i = 0; i <= NUM_CH; i++) cnt_p1[i] <= nxt[i];
                ovf_p1 <= ovf_p1 | carry;
                if (fire)         win_p1 <= '0;
                else if (counted) win_p1 <= win_inc;
            end
        end
    end

    assign snap_valid = vld_p1;
    assign overflow   = ovf_p1;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i <= NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) rd_data = shadow_p1[i];
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench for perf_counter_bank, built with CNT_W=8 so that overflow and
// wrap/saturation are reachable in a short run. The reference model tracks
// the exact unbounded event totals since the last clear/reset and derives
// the counter value (clamp or modulo) and overflow (total > max) from them.
module tb_perf_counter_bank;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 8;
    localparam int INC_W  = 4;
    localparam int SEL_W  = $clog2(NUM_CH+2);
    localparam longint MAXV = (64'd1 << CNT_W) - 1;
    localparam longint WMOD = 64'h1_0000_0000;
`ifdef PERF_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst, en, clear, snap_req, snap_valid;
    logic [NUM_CH*INC_W-1:0] inc;
    logic [NUM_CH-1:0]       mode;
    logic [31:0]             window_len;
    logic [SEL_W-1:0]        rd_sel;
    logic [CNT_W-1:0]        rd_data;
    logic [NUM_CH:0]         overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    longint tot_m    [NUM_CH+1];
    longint shadow_m [NUM_CH+1];
    longint win_m;
    bit     sv_m;

    always #50 clk = ~clk;

    perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .INC_W(INC_W)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .inc(inc), .mode(mode),
        .window_len(window_len), .snap_req(snap_req), .snap_valid(snap_valid),
        .rd_sel(rd_sel), .rd_data(rd_data), .overflow(overflow)
    );

    function automatic longint clamp(input longint v);
        if (SAT) return (v > MAXV) ? MAXV : v;
        return v % (MAXV + 1);
    endfunction

    function automatic logic [NUM_CH:0] exp_ovf();
        logic [NUM_CH:0] v;
        for (int i = 0; i <= NUM_CH; i++) v[i] = (tot_m[i] > MAXV);
        return v;
    endfunction

    function automatic longint exp_rd(input int sel);
        if (sel <= NUM_CH) return shadow_m[sel];
        return 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of the model, evaluated with the inputs currently driven.
    task automatic model_step();
        longint pend [NUM_CH+1];
        longint a;
        bit counted, fire;
        if (rst) begin
            for (int i = 0; i <= NUM_CH; i++) begin
                tot_m[i] = 0;
                shadow_m[i] = 0;
            end
            win_m = 0;
            sv_m  = 0;
            return;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            a = 0;
            if (en) a = mode[i] ? longint'(inc[i*INC_W +: INC_W] != 0)
                                : longint'(inc[i*INC_W +: INC_W]);
            pend[i] = tot_m[i] + a;
        end
        pend[NUM_CH] = tot_m[NUM_CH] + (en ? 1 : 0);
        counted = en && !clear;
        fire = snap_req ||
               (counted && window_len != 0 && ((win_m + 1) % WMOD) == longint'(window_len));
        if (fire)
            for (int i = 0; i <= NUM_CH; i++) shadow_m[i] = clamp(pend[i]);
        sv_m = fire;
        if (clear) begin
            for (int i = 0; i <= NUM_CH; i++) tot_m[i] = 0;
            win_m = 0;
        end else begin
            for (int i = 0; i <= NUM_CH; i++) tot_m[i] = pend[i];
            if (fire)         win_m = 0;
            else if (counted) win_m = (win_m + 1) % WMOD;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("snap_valid", snap_valid, sv_m);
        check("overflow", overflow, exp_ovf());
    endtask

    task automatic read_chk(input int sel, input string tag);
        rd_sel = SEL_W'(sel);
        #1;
        check(tag, rd_data, exp_rd(sel));
    endtask

    task automatic read_all();
        for (int s = 0; s <= NUM_CH + 1; s++) read_chk(s, "rd_model");
    endtask

    task automatic read_const(input int sel, input string tag, input longint v);
        rd_sel = SEL_W'(sel);
        #1;
        check(tag, rd_data, v);
    endtask

    task automatic set_inc(input int ch, input int v);
        inc[ch*INC_W +: INC_W] = INC_W'(v);
    endtask

    task automatic snap_frozen();
        en = 1'b0; snap_req = 1'b1;
        tick();
        snap_req = 1'b0; en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clear = 1'b0; snap_req = 1'b0;
        inc = '0; mode = '0; window_len = 32'd0; rd_sel = '0;
        win_m = 0; sv_m = 0;
        for (int i = 0; i <= NUM_CH; i++) begin tot_m[i] = 0; shadow_m[i] = 0; end

        // Reset state
        tick(); tick();
        check("rst_snap_valid", snap_valid, 0);
        check("rst_overflow", overflow, 0);
        read_all();
        rst = 1'b0;

        // Basic count with periodic snapshot every 10 cycles
        window_len = 32'd10; en = 1'b1; mode = 8'b0000_0010;
        for (int t = 0; t < 20; t++) begin
            set_inc(0, 3);
            set_inc(1, (t % 2) ? 2 : 0);
            tick();
            if (t == 9) begin
                check("basic_valid10", snap_valid, 1);
                read_const(0, "basic_ch0", 30);
                read_const(1, "basic_ch1", 5);
                read_const(NUM_CH, "basic_cyc", 10);
            end
        end
        read_all();

        // Freeze mid-window, then on-demand snapshot while frozen
        for (int t = 20; t < 23; t++) begin
            set_inc(0, 3);
            set_inc(1, (t % 2) ? 2 : 0);
            tick();
        end
        en = 1'b0;
        for (int t = 0; t < 5; t++) begin
            inc = $urandom;
            tick();
            check("freeze_no_snap", snap_valid, 0);
        end
        inc = $urandom;
        snap_frozen();
        check("freeze_valid", snap_valid, 1);
        read_const(0, "freeze_ch0", 69);
        read_const(1, "freeze_ch1", 11);
        read_const(NUM_CH, "freeze_cyc", 23);

        // Coincident clear and snapshot
        window_len = 32'd0; mode = '0; inc = '0;
        clear = 1'b1; tick(); clear = 1'b0;
        set_inc(0, 1);
        for (int t = 0; t < 17; t++) tick();
        set_inc(0, 2); clear = 1'b1; snap_req = 1'b1;
        tick();
        clear = 1'b0; snap_req = 1'b0;
        read_const(0, "coinc_shadow", 19);
        check("coinc_ovf_clr", overflow, 0);
        set_inc(0, 1);
        for (int t = 0; t < 4; t++) tick();
        snap_frozen();
        read_const(0, "coinc_next", 4);

        // Overflow on ch0
        inc = '0; clear = 1'b1; tick(); clear = 1'b0;
        set_inc(0, 15);
        for (int t = 0; t < 20; t++) tick();
        snap_frozen();
        read_const(0, "ovf_shadow", SAT ? 255 : 44);
        check("ovf_bit0", overflow[0], 1);
        read_const(NUM_CH, "ovf_cyc", 20);

        // Reset mid-window with nonzero counts
        window_len = 32'd10; mode = 8'($urandom);
        for (int t = 0; t < 14; t++) begin inc = $urandom; tick(); end
        rst = 1'b1; snap_req = 1'b1; tick();
        check("rst_mid_valid", snap_valid, 0);
        snap_req = 1'b0; tick();
        rst = 1'b0;
        check("rst_mid_ovf", overflow, 0);
        for (int s = 0; s <= NUM_CH + 1; s++) read_const(s, "rst_mid_rd", 0);
        mode = '0;
        for (int c = 0; c < NUM_CH; c++) set_inc(c, 1);
        for (int t = 0; t < 3; t++) tick();
        snap_frozen();
        read_const(0, "resume_ch0", 3);
        read_const(NUM_CH, "resume_cyc", 3);
        read_const(NUM_CH + 1, "oor_read", 0);

        // Randomized run against the model
        window_len = 32'd7; mode = 8'($urandom);
        for (int t = 0; t < 600; t++) begin
            rst      = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 9) != 0);
            clear    = ($urandom_range(0, 39) == 0);
            snap_req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 59) == 0) window_len = 32'($urandom_range(0, 20));
            if ($urandom_range(0, 29) == 0) mode = 8'($urandom);
            inc = $urandom;
            tick();
            read_chk(int'($urandom_range(0, (1 << SEL_W) - 1)), "rd_rand");
            if (t % 50 == 49) read_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
